// File: rtl/tl_uart_ctrl_initiator.sv
// TileLink-UL initiator for the TLUART control port: turns one 32-bit register
// command into a single Get/PutFullData beat and returns the D-channel result.
module tl_uart_ctrl_initiator #(
  parameter logic [6:0] SOURCE_ID      = 7'd0,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         CNT_W          = 11
) (
  input  logic        clock,
  input  logic        reset,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [30:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  // TileLink A channel
  output logic        a_valid,
  input  logic        a_ready,
  output logic [2:0]  a_bits_opcode,
  output logic [2:0]  a_bits_param,
  output logic [1:0]  a_bits_size,
  output logic [6:0]  a_bits_source,
  output logic [30:0] a_bits_address,
  output logic [7:0]  a_bits_mask,
  output logic [63:0] a_bits_data,
  output logic        a_bits_corrupt,
  // TileLink D channel
  output logic        d_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_bits_opcode,
  input  logic [1:0]  d_bits_size,
  input  logic [6:0]  d_bits_source,
  input  logic [63:0] d_bits_data,
  input  logic        d_bits_denied,
  input  logic        d_bits_corrupt,
  // debug: 0=IDLE 1=A_SEND 2=D_WAIT 3=RSP 4=DRAIN
  output logic [2:0]  dbg_state
);

  // Handshakes: a beat transfers on the rising edge where valid && ready; a
  // valid source holds its payload stable until that edge and never waits on ready.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_A_SEND = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_RSP    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [30:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             error_q, error_d;
  logic             drain_q, drain_d;

  logic             d_match;
  logic             d_err;
  logic [31:0]      d_word;
  logic             unused_d_size;

  assign unused_d_size = ^d_bits_size;

  assign d_match = d_valid && (d_bits_source == SOURCE_ID);
  assign d_err   = d_bits_denied
                 | (d_bits_corrupt & ~write_q)
                 | (write_q ? (d_bits_opcode != 3'd0) : (d_bits_opcode != 3'd1));
  assign d_word  = addr_q[2] ? d_bits_data[63:32] : d_bits_data[31:0];

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          error_d = 1'b0;
          drain_d = 1'b0;
          state_d = ST_A_SEND;
        end
      end
      ST_A_SEND: begin
        if (a_ready) begin
          cnt_d   = '0;
          state_d = ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        // A matching beat in the expiry cycle takes priority over the timeout.
        if (d_match) begin
          error_d = d_err;
          rdata_d = (write_q || d_err) ? 32'h0 : d_word;
          state_d = ST_RSP;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          rdata_d = '0;
          drain_d = 1'b1;
          state_d = ST_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // The lost response must still be swallowed before a new request goes out.
        if (d_match) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      drain_q <= drain_d;
    end
  end

  assign cmd_ready      = reset && (state_q == ST_IDLE);
  assign a_valid        = (state_q == ST_A_SEND);
  assign d_ready        = (state_q == ST_D_WAIT) || (state_q == ST_DRAIN);
  assign rsp_valid      = (state_q == ST_RSP);
  assign rsp_rdata      = rdata_q;
  assign rsp_error      = error_q;

  assign a_bits_opcode  = write_q ? 3'd0 : 3'd4;
  assign a_bits_param   = 3'd0;
  assign a_bits_size    = 2'd2;
  assign a_bits_source  = SOURCE_ID;
  assign a_bits_address = addr_q;
  assign a_bits_mask    = addr_q[2] ? 8'hF0 : 8'h0F;
  assign a_bits_data    = {wdata_q, wdata_q};
  assign a_bits_corrupt = 1'b0;

  assign dbg_state      = state_q;

endmodule

// File: tb/tb_tl_uart_ctrl_initiator.sv
// Self-checking bench for tl_uart_ctrl_initiator: directed scenarios plus
// randomized transactions checked against a rule-level response model.
module tb_tl_uart_ctrl_initiator;

  localparam int         TO  = 16;
  localparam int         CW  = 5;
  localparam logic [6:0] SID = 7'd0;

  logic        clock;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [30:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        a_valid, a_ready;
  logic [2:0]  a_bits_opcode, a_bits_param;
  logic [1:0]  a_bits_size;
  logic [6:0]  a_bits_source;
  logic [30:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        a_bits_corrupt;
  logic        d_ready, d_valid;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_size;
  logic [6:0]  d_bits_source;
  logic [63:0] d_bits_data;
  logic        d_bits_denied, d_bits_corrupt;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int a_fires = 0;
  logic [32:0] exp_q[$];

  // captured by the driver for the test tasks to compare
  logic [2:0]  g_opcode, g_param;
  logic [1:0]  g_size;
  logic [6:0]  g_source;
  logic [30:0] g_addr;
  logic [7:0]  g_mask;
  logic [63:0] g_data;
  logic        g_corrupt, g_a_valid, g_a_stable, g_hold_ok;
  int          g_a_valid_lo, g_lat;
  logic [31:0] g_rdata;
  logic        g_error;

  tl_uart_ctrl_initiator #(.SOURCE_ID(SID), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .a_valid(a_valid), .a_ready(a_ready), .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
    .a_bits_size(a_bits_size), .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
    .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
    .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode), .d_bits_size(d_bits_size),
    .d_bits_source(d_bits_source), .d_bits_data(d_bits_data), .d_bits_denied(d_bits_denied),
    .d_bits_corrupt(d_bits_corrupt), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset && a_valid && a_ready) a_fires <= a_fires + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: response each command must produce, from the protocol rules.
  function automatic logic [32:0] model_rsp(input logic wr, input logic [30:0] addr,
                                            input logic [2:0] op, input logic [63:0] data,
                                            input logic den, input logic cor, input logic lost);
    logic        err;
    logic [2:0]  want_op;
    logic [31:0] word;
    if (lost) return {1'b1, 32'h0};
    want_op = wr ? 3'd0 : 3'd1;
    err  = den || (cor && !wr) || (op != want_op);
    word = addr[2] ? data[63:32] : data[31:0];
    return {err, (wr || err) ? 32'h0 : word};
  endfunction

  // driver: one full command through A, D and response phases
  task automatic run_txn(input logic wr, input logic [30:0] addr, input logic [31:0] wd,
                         input int a_stall, input bit send_d, input int n_foreign,
                         input logic [6:0] fsrc, input int d_delay, input logic [2:0] op,
                         input logic [63:0] data, input logic den, input logic cor,
                         input int rsp_delay);
    int guard;
    int t_acc;
    logic [133:0] snap;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    guard = 0;
    while (!cmd_ready && guard < 100) begin @(negedge clock); guard++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 31'($urandom()); cmd_wdata = $urandom();
    g_a_stable = 1'b1; g_a_valid_lo = 0;
    snap = {a_bits_opcode, a_bits_address, a_bits_mask, a_bits_data};
    for (int i = 0; i < a_stall; i++) begin
      a_ready = 1'b0;
      if (!a_valid) g_a_valid_lo++;
      if ({a_bits_opcode, a_bits_address, a_bits_mask, a_bits_data} !== snap) g_a_stable = 1'b0;
      @(negedge clock);
    end
    if ({a_bits_opcode, a_bits_address, a_bits_mask, a_bits_data} !== snap) g_a_stable = 1'b0;
    g_a_valid = a_valid; g_opcode = a_bits_opcode; g_param = a_bits_param; g_size = a_bits_size;
    g_source = a_bits_source; g_addr = a_bits_address; g_mask = a_bits_mask;
    g_data = a_bits_data; g_corrupt = a_bits_corrupt;
    a_ready = 1'b1;
    @(negedge clock);
    a_ready = 1'b0;
    if (send_d) begin
      for (int i = 0; i < n_foreign; i++) begin
        d_valid = 1'b1;
        d_bits_source = (fsrc != 7'd0) ? fsrc : 7'($urandom_range(1, 127));
        d_bits_opcode = 3'($urandom_range(0, 1)); d_bits_data = {$urandom(), $urandom()};
        d_bits_denied = 1'b0; d_bits_corrupt = 1'b0;
        @(negedge clock);
      end
      d_valid = 1'b0;
      for (int i = 0; i < d_delay; i++) @(negedge clock);
      d_valid = 1'b1; d_bits_source = SID; d_bits_opcode = op; d_bits_size = 2'd2;
      d_bits_data = data; d_bits_denied = den; d_bits_corrupt = cor;
      @(negedge clock);
      d_valid = 1'b0; d_bits_data = {$urandom(), $urandom()}; d_bits_opcode = 3'($urandom_range(0, 7));
      d_bits_denied = 1'b0; d_bits_corrupt = 1'b0;
    end
    guard = 0;
    while (!rsp_valid && guard < 200) begin @(negedge clock); guard++; end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_wait: rsp_valid=%0b required 1 within 200 cycles", rsp_valid);
      g_lat = -1; g_rdata = 32'hx; g_error = 1'bx;
      return;
    end
    g_lat = cyc - t_acc; g_rdata = rsp_rdata; g_error = rsp_error;
    g_hold_ok = 1'b1;
    for (int i = 0; i < rsp_delay; i++) begin
      rsp_ready = 1'b0;
      @(negedge clock);
      if (!rsp_valid || rsp_rdata !== g_rdata || rsp_error !== g_error) g_hold_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0; a_ready = 0;
    d_valid = 0; d_bits_opcode = 0; d_bits_size = 0; d_bits_source = 0; d_bits_data = '0;
    d_bits_denied = 0; d_bits_corrupt = 0;
    repeat (3) @(negedge clock);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got=%0b exp=0", cmd_ready); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rst_a_valid: got=%0b exp=0", a_valid); end
    total++; if (d_ready !== 1'b0) begin bad++; $display("FAIL rst_d_ready: got=%0b exp=0", d_ready); end
    total++; if ({rsp_valid, rsp_error, rsp_rdata} !== 34'h0) begin
      bad++; $display("FAIL rst_rsp: got v=%0b e=%0b d=%h exp all 0", rsp_valid, rsp_error, rsp_rdata);
    end
    reset = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got=%0b exp=1", cmd_ready); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state: got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_write();
    run_txn(1'b1, 31'h1000_0018, 32'h0000_0010, 0, 1, 0, 7'd0, 0, 3'd0, 64'h0, 0, 0, 0);
    total++; if (g_opcode !== 3'd0) begin bad++; $display("FAIL wr_opcode: got=%0d exp=0", g_opcode); end
    total++; if (g_size !== 2'd2 || g_param !== 3'd0 || g_corrupt !== 1'b0 || g_source !== SID) begin
      bad++; $display("FAIL wr_consts: size=%0d param=%0d corrupt=%0b src=%0d exp 2/0/0/%0d",
                      g_size, g_param, g_corrupt, g_source, SID);
    end
    total++; if (g_mask !== 8'h0F) begin bad++; $display("FAIL wr_mask: got=%h exp=0f", g_mask); end
    total++; if (g_data !== 64'h0000_0010_0000_0010) begin bad++; $display("FAIL wr_data: got=%h exp=0000001000000010", g_data); end
    total++; if (g_addr !== 31'h1000_0018) begin bad++; $display("FAIL wr_addr: got=%h exp=10000018", g_addr); end
    total++; if ({g_error, g_rdata} !== 33'h0) begin bad++; $display("FAIL wr_rsp: got e=%0b d=%h exp 0/0", g_error, g_rdata); end
    total++; if (g_lat !== 3) begin bad++; $display("FAIL wr_latency: got=%0d exp=3", g_lat); end
  endtask

  task automatic test_read();
    run_txn(1'b0, 31'h1000_0004, 32'h0, 0, 1, 0, 7'd0, 0, 3'd1, 64'hDEAD_BEEF_0000_0001, 0, 0, 2);
    total++; if (g_opcode !== 3'd4) begin bad++; $display("FAIL rd_opcode: got=%0d exp=4", g_opcode); end
    total++; if (g_mask !== 8'hF0) begin bad++; $display("FAIL rd_mask: got=%h exp=f0", g_mask); end
    total++; if (g_rdata !== 32'hDEAD_BEEF || g_error !== 1'b0) begin
      bad++; $display("FAIL rd_rsp: got e=%0b d=%h exp 0/deadbeef", g_error, g_rdata);
    end
    total++; if (g_hold_ok !== 1'b1) begin bad++; $display("FAIL rd_rsp_hold: got=%0b exp=1", g_hold_ok); end
  endtask

  task automatic test_a_stall();
    int f0;
    f0 = a_fires;
    run_txn(1'b1, 31'h0000_0008, 32'hA5A5_1234, 5, 1, 0, 7'd0, 0, 3'd0, 64'h0, 0, 0, 0);
    total++; if (g_a_stable !== 1'b1 || g_a_valid_lo !== 0 || g_a_valid !== 1'b1) begin
      bad++; $display("FAIL stall_stable: stable=%0b valid_low_cycles=%0d exp 1/0", g_a_stable, g_a_valid_lo);
    end
    total++; if (a_fires - f0 !== 1) begin bad++; $display("FAIL stall_fires: got=%0d exp=1", a_fires - f0); end
    total++; if (g_lat !== 8) begin bad++; $display("FAIL stall_latency: got=%0d exp=8", g_lat); end
  endtask

  task automatic test_timeout_drain();
    run_txn(1'b0, 31'h0000_0010, 32'h0, 0, 0, 0, 7'd0, 0, 3'd1, 64'h0, 0, 0, 0);
    total++; if (g_lat !== TO + 2) begin bad++; $display("FAIL to_latency: got=%0d exp=%0d", g_lat, TO + 2); end
    total++; if (g_error !== 1'b1 || g_rdata !== 32'h0) begin
      bad++; $display("FAIL to_rsp: got e=%0b d=%h exp 1/0", g_error, g_rdata);
    end
    total++; if (cmd_ready !== 1'b0 || d_ready !== 1'b1) begin
      bad++; $display("FAIL drain_enter: cmd_ready=%0b d_ready=%0b exp 0/1", cmd_ready, d_ready);
    end
    repeat (3) @(negedge clock);
    d_valid = 1'b1; d_bits_source = 7'd3; d_bits_opcode = 3'd1;
    @(negedge clock);
    d_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL drain_hold: cmd_ready=%0b exp=0", cmd_ready); end
    d_valid = 1'b1; d_bits_source = SID; d_bits_opcode = 3'd1;
    @(negedge clock);
    d_valid = 1'b0;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL drain_exit: cmd_ready=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_expiry_win();
    run_txn(1'b0, 31'h0000_0020, 32'h0, 0, 1, 0, 7'd0, TO - 1, 3'd1, 64'h1111_2222_3333_4444, 0, 0, 0);
    total++; if (g_error !== 1'b0 || g_rdata !== 32'h3333_4444) begin
      bad++; $display("FAIL expiry_win: got e=%0b d=%h exp 0/33334444", g_error, g_rdata);
    end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL expiry_idle: cmd_ready=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_foreign_denied();
    run_txn(1'b0, 31'h0000_0004, 32'h0, 0, 1, 1, 7'd5, 0, 3'd1, 64'h0123_4567_89AB_CDEF, 1, 0, 0);
    total++; if (g_error !== 1'b1 || g_rdata !== 32'h0) begin
      bad++; $display("FAIL foreign_denied: got e=%0b d=%h exp 1/0", g_error, g_rdata);
    end
    total++; if (g_lat !== 4) begin bad++; $display("FAIL foreign_latency: got=%0d exp=4", g_lat); end
  endtask

  task automatic test_random();
    logic        wr, den, cor;
    logic [30:0] addr;
    logic [31:0] wd;
    logic [2:0]  op;
    logic [63:0] data;
    logic [32:0] exp;
    int          st, nf, dd, rd;
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 31'($urandom()) & ~31'h3;
      wd   = $urandom();
      data = {$urandom(), $urandom()};
      op   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : (wr ? 3'd0 : 3'd1);
      den  = ($urandom_range(0, 7) == 0);
      cor  = ($urandom_range(0, 5) == 0);
      st = $urandom_range(0, 3); nf = $urandom_range(0, 3); dd = $urandom_range(0, 4);
      rd = $urandom_range(0, 2);
      exp_q.push_back(model_rsp(wr, addr, op, data, den, cor, 1'b0));
      run_txn(wr, addr, wd, st, 1, nf, 7'd0, dd, op, data, den, cor, rd);
      exp = exp_q.pop_front();
      total++; if ({g_error, g_rdata} !== exp) begin
        bad++; $display("FAIL rnd_rsp[%0d]: got e=%0b d=%h exp e=%0b d=%h", n, g_error, g_rdata, exp[32], exp[31:0]);
      end
      total++; if (g_opcode !== (wr ? 3'd0 : 3'd4) || g_addr !== addr || g_data !== {wd, wd}
                   || g_mask !== (addr[2] ? 8'hF0 : 8'h0F)) begin
        bad++; $display("FAIL rnd_a[%0d]: got op=%0d a=%h m=%h d=%h exp op=%0d a=%h d=%h", n, g_opcode,
                        g_addr, g_mask, g_data, wr ? 4'd0 : 4'd4, addr, {wd, wd});
      end
      total++; if (g_lat !== 3 + st + nf + dd) begin
        bad++; $display("FAIL rnd_lat[%0d]: got=%0d exp=%0d", n, g_lat, 3 + st + nf + dd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 31'h40; cmd_wdata = 32'h55;
    @(negedge clock);
    cmd_valid = 1'b0;
    f0 = a_fires;
    total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL mid_a_valid: got=%0b exp=1", a_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (a_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL mid_async: a_valid=%0b cmd_ready=%0b exp 0/0", a_valid, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || a_fires !== f0) begin
      bad++; $display("FAIL mid_release: cmd_ready=%0b rsp_valid=%0b fires=%0d exp 1/0/%0d",
                      cmd_ready, rsp_valid, a_fires, f0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_a_stall();
    test_timeout_drain();
    test_expiry_win();
    test_foreign_denied();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_uart_ctrl_initiator.md
Name: tl_uart_ctrl_initiator

Overview:
- TileLink-UL initiator (master) that drives the control port of a TLUART instance from a simple register command interface.
- Converts one 32-bit read/write command into a single A-channel Get/PutFullData beat on a 64-bit data bus.
- Collects the matching D-channel response and returns read data or error.
- Sits in the same clock domain as the UART; used by test/boot logic to program divisor, txctrl and rxctrl, and to poll txdata/rxdata.

Parameters:
- SOURCE_ID, 0, 7-bit TileLink source tag driven on every A beat.
- TIMEOUT_CYCLES, 1024, D_WAIT cycles before the request is declared lost; minimum 2.
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  block clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=PutFullData, 0=Get
- cmd_addr  in  31  byte address; bits [1:0] must be 0
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes/errors)
- rsp_error  out  1  D denied/corrupt, or timeout
- a_valid  out  1  A-channel valid
- a_ready  in  1  A-channel ready
- a_bits_opcode  out  3  4=Get, 0=PutFullData
- a_bits_param  out  3  constant 0
- a_bits_size  out  2  constant 2 (4 bytes)
- a_bits_source  out  7  SOURCE_ID
- a_bits_address  out  31  latched cmd_addr
- a_bits_mask  out  8  addr[2] ? 8'hF0 : 8'h0F
- a_bits_data  out  64  {wdata, wdata}
- a_bits_corrupt  out  1  constant 0
- d_ready  out  1  D-channel ready
- d_valid  in  1  D-channel valid
- d_bits_opcode  in  3  0=AccessAck, 1=AccessAckData
- d_bits_size  in  2  response size (ignored)
- d_bits_source  in  7  response tag
- d_bits_data  in  64  response data
- d_bits_denied  in  1  error response
- d_bits_corrupt  in  1  data corrupt

Behaviour:
Reset values (reset low, asynchronous):
- state=IDLE; cmd_ready=0 during reset, 1 in IDLE.
- a_valid=0, d_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, timeout counter=0, all latches 0.

FSM states: IDLE, A_SEND, D_WAIT, RSP, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch write/addr/wdata, go to A_SEND.
- A_SEND:
  - a_valid=1 with latched fields; fields stay stable while a_valid && !a_ready.
  - On a_ready: go to D_WAIT, clear counter.
  - No timeout is applied in this state.
- D_WAIT:
  - d_ready=1; counter increments each cycle.
  - On d_valid with d_bits_source==SOURCE_ID: capture response, go to RSP.
    - rsp_rdata = addr[2] ? d_data[63:32] : d_data[31:0] for Get; 0 for Put.
    - rsp_error = denied | (corrupt & Get) | opcode mismatch (Get expects 1, Put expects 0).
  - d_valid with any other source: consumed and dropped; no state change, counter keeps running.
  - Counter reaching TIMEOUT_CYCLES-1 with no match: rsp_error=1, rsp_rdata=0, go to RSP with a pending-drain flag set.
  - A matching d_valid in the expiry cycle wins over the timeout.
- RSP:
  - rsp_valid=1, outputs held until rsp_ready.
  - On rsp_ready: go to DRAIN if the pending-drain flag is set, else IDLE.
  - d_ready=0 here.
- DRAIN:
  - d_ready=1; cmd_ready=0.
  - On d_valid with source==SOURCE_ID: discard, go to IDLE.
  - Waits indefinitely; only reset exits otherwise.

Latency and throughput:
- Exactly one transaction outstanding.
- Minimum command-to-rsp_valid latency is 3 cycles: accept, A fire, D capture, with zero-wait a_ready and d_valid.

Reset mid-operation:
- All state clears immediately; any in-flight A or D beat is abandoned.
- The responder side is reset by the same domain reset.

Test Plan:
- Write 0x0000_0010 to 0x1000_0018 (addr[2]=0), a_ready=1: A beat opcode=0, size=2, mask=0x0F, data=0x0000_0010_0000_0010. AccessAck next cycle -> rsp_valid, rsp_error=0, rsp_rdata=0.
- Read 0x1000_0004 (addr[2]=1), AccessAckData data=0xDEAD_BEEF_0000_0001: rsp_rdata=0xDEADBEEF, mask=0xF0, rsp_error=0.
- a_ready held low 5 cycles during write: a_valid stays 1 and address/data stay stable for all 5 cycles; exactly one A fire.
- No D response for TIMEOUT_CYCLES=16: rsp_valid with rsp_error=1 after 16 D_WAIT cycles. A late ack after rsp_ready is absorbed in DRAIN; cmd_ready returns to 1 the next cycle.
- d_valid with source=5 while SOURCE_ID=0, then source=0 with denied=1: first beat dropped; rsp_error=1.
- Reset asserted while in A_SEND: a_valid drops to 0 asynchronously. After release, cmd_ready=1 and rsp_valid=0.
